// File: rtl/pe_pkg.sv
// Shared width defaults and saturation-bound helpers for the double-buffered-weight PE.
package pe_pkg;

    localparam int unsigned PE_DATA_W   = 8;
    localparam int unsigned PE_WEIGHT_W = 8;
    localparam int unsigned PE_ACC_W    = 16;

    // Largest representable value of a w-bit word (w <= 63).
    function automatic logic [63:0] sat_max(input int unsigned w, input bit sgn);
        logic [63:0] one;
        one = 64'd1;
        return sgn ? ((one << (w - 1)) - 64'd1) : ((one << w) - 64'd1);
    endfunction

    // Smallest representable value, as a 64-bit pattern to be truncated to w bits.
    function automatic logic [63:0] sat_min(input int unsigned w, input bit sgn);
        logic [63:0] one;
        one = 64'd1;
        return sgn ? ~((one << (w - 1)) - 64'd1) : 64'd0;
    endfunction

endpackage

// File: rtl/pe_mac_core.sv
// Combinational multiply-add: sum_out = sum_in + data*weight, with operand extension.
// Defining PE_SATURATE_EN clamps the sum instead of wrapping and adds the clamp output.
module pe_mac_core
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W   = PE_DATA_W,
    parameter int unsigned WEIGHT_W = PE_WEIGHT_W,
    parameter int unsigned ACC_W    = PE_ACC_W,
    parameter bit          SIGNED   = 1'b1
) (
    input  logic [DATA_W-1:0]   data,
    input  logic [WEIGHT_W-1:0] weight,
    input  logic [ACC_W-1:0]    sum_in,
    output logic [ACC_W-1:0]    sum_out
`ifdef PE_SATURATE_EN
    ,
    output logic                clamp
`endif
);

    localparam int unsigned P_W = DATA_W + WEIGHT_W;
`ifdef PE_SATURATE_EN
    // One guard bit above the accumulator exposes overflow.
    localparam int unsigned X_W = ACC_W + 1;
`else
    localparam int unsigned X_W = ACC_W;
`endif

    logic [P_W-1:0] data_x;
    logic [P_W-1:0] weight_x;
    logic [P_W-1:0] prod;
    logic [X_W-1:0] prod_x;
    logic [X_W-1:0] sum_x;
    logic [X_W-1:0] total;

    // Extend operands to full product width so the low P_W bits are exact.
    always_comb begin
        if (SIGNED) begin
            data_x   = P_W'($signed(data));
            weight_x = P_W'($signed(weight));
        end else begin
            data_x   = P_W'(data);
            weight_x = P_W'(weight);
        end
        prod = data_x * weight_x;
        if (SIGNED) begin
            prod_x = X_W'($signed(prod));
            sum_x  = X_W'($signed(sum_in));
        end else begin
            prod_x = X_W'(prod);
            sum_x  = X_W'(sum_in);
        end
        total = sum_x + prod_x;
    end

`ifdef PE_SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W, SIGNED));
    localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W, SIGNED));

    // Signed overflow: guard and sign bits disagree; unsigned overflow: carry out.
    always_comb begin
        clamp   = 1'b0;
        sum_out = total[ACC_W-1:0];
        if (SIGNED) begin
            if (total[ACC_W] != total[ACC_W-1]) begin
                clamp   = 1'b1;
                sum_out = total[ACC_W] ? SAT_MIN : SAT_MAX;
            end
        end else if (total[ACC_W]) begin
            clamp   = 1'b1;
            sum_out = SAT_MAX;
        end
    end
`else
    assign sum_out = total;
`endif

endmodule

// File: rtl/pe_dbw.sv
// Weight-stationary systolic MAC cell with a shadow weight on a shift chain and a rippling swap token.
// Build option PE_SATURATE_EN: saturating accumulate plus a registered sat_flag output.
module pe_dbw
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W   = PE_DATA_W,
    parameter int unsigned WEIGHT_W = PE_WEIGHT_W,
    parameter int unsigned ACC_W    = PE_ACC_W,   // must be >= DATA_W + WEIGHT_W
    parameter bit          SIGNED   = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                active,
    input  logic [DATA_W-1:0]   datain,
    input  logic [ACC_W-1:0]    sumin,
    input  logic [WEIGHT_W-1:0] win,
    input  logic                wwrite,
    input  logic                wswap,
    output logic [ACC_W-1:0]    maccout,
    output logic [DATA_W-1:0]   dataout,
    output logic [WEIGHT_W-1:0] wout,
    output logic                wwriteout,
    output logic                wswapout,
    output logic                activeout,
    output logic                wvalid
`ifdef PE_SATURATE_EN
    ,
    output logic                sat_flag
`endif
);

    logic [WEIGHT_W-1:0] shadow;
    logic [WEIGHT_W-1:0] act_w;
    logic [ACC_W-1:0]    mac_sum;
`ifdef PE_SATURATE_EN
    logic                mac_clamp;
`endif

    pe_mac_core #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W),
        .ACC_W    (ACC_W),
        .SIGNED   (SIGNED)
    ) u_mac (
        .data    (datain),
        .weight  (act_w),
        .sum_in  (sumin),
        .sum_out (mac_sum)
`ifdef PE_SATURATE_EN
        ,
        .clamp   (mac_clamp)
`endif
    );

    assign wout = shadow;

    // All state updates use pre-edge values, so a swap reaches the MAC one cycle later.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            shadow    <= '0;
            act_w     <= '0;
            wvalid    <= 1'b0;
            maccout   <= '0;
            dataout   <= '0;
            wwriteout <= 1'b0;
            wswapout  <= 1'b0;
            activeout <= 1'b0;
`ifdef PE_SATURATE_EN
            sat_flag  <= 1'b0;
`endif
        end else begin
            if (wwrite) begin
                shadow <= win;
            end
            if (wswap) begin
                act_w  <= shadow;
                wvalid <= 1'b1;
            end
            if (active) begin
                maccout  <= mac_sum;
                dataout  <= datain;
`ifdef PE_SATURATE_EN
                sat_flag <= mac_clamp;
`endif
            end
            wwriteout <= wwrite;
            wswapout  <= wswap;
            activeout <= active;
        end
    end

endmodule

// File: tb/tb_pe_dbw.sv
// Self-checking bench for pe_dbw (default widths, SIGNED=1); follows PE_SATURATE_EN if defined.
module tb_pe_dbw;

    logic        clock;
    logic        reset_n;
    logic        active;
    logic [7:0]  datain;
    logic [15:0] sumin;
    logic [7:0]  win;
    logic        wwrite;
    logic        wswap;
    logic [15:0] maccout;
    logic [7:0]  dataout;
    logic [7:0]  wout;
    logic        wwriteout;
    logic        wswapout;
    logic        activeout;
    logic        wvalid;
`ifdef PE_SATURATE_EN
    logic        sat_flag;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_shadow, m_act, m_valid, m_mac, m_dout, m_wwo, m_wso, m_ao, m_sat;

    pe_dbw dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .active    (active),
        .datain    (datain),
        .sumin     (sumin),
        .win       (win),
        .wwrite    (wwrite),
        .wswap     (wswap),
        .maccout   (maccout),
        .dataout   (dataout),
        .wout      (wout),
        .wwriteout (wwriteout),
        .wswapout  (wswapout),
        .activeout (activeout),
        .wvalid    (wvalid)
`ifdef PE_SATURATE_EN
        ,
        .sat_flag  (sat_flag)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: true integer result, then wrap or clamp to 16 bits.
    task automatic mac_ref(input int s_u, input int d_u, input int w_u, output int res, output int clamped);
        int s, d, w, r;
        s = (s_u >= 32768) ? s_u - 65536 : s_u;
        d = (d_u >= 128) ? d_u - 256 : d_u;
        w = (w_u >= 128) ? w_u - 256 : w_u;
        r = s + d * w;
        clamped = 0;
`ifdef PE_SATURATE_EN
        if (r > 32767) begin
            r = 32767;
            clamped = 1;
        end else if (r < -32768) begin
            r = -32768;
            clamped = 1;
        end
`endif
        res = r & 32'hFFFF;
    endtask

    // One clock edge: advance the model from pre-edge inputs, then compare every output.
    task automatic tick(input string tag);
        int res, cl;
        @(posedge clock);
        if (!reset_n) begin
            m_shadow = 0; m_act = 0; m_valid = 0; m_mac = 0; m_dout = 0;
            m_wwo = 0; m_wso = 0; m_ao = 0; m_sat = 0;
        end else begin
            if (active) begin
                mac_ref(int'(sumin), int'(datain), m_act, res, cl);
                m_mac  = res;
                m_dout = int'(datain);
                m_sat  = cl;
            end
            if (wswap) begin
                m_act   = m_shadow;
                m_valid = 1;
            end
            if (wwrite) m_shadow = int'(win);
            m_wwo = int'(wwrite);
            m_wso = int'(wswap);
            m_ao  = int'(active);
        end
        #1;
        check({tag, ".maccout"},   32'(maccout),   32'(m_mac));
        check({tag, ".dataout"},   32'(dataout),   32'(m_dout));
        check({tag, ".wout"},      32'(wout),      32'(m_shadow));
        check({tag, ".wwriteout"}, 32'(wwriteout), 32'(m_wwo));
        check({tag, ".wswapout"},  32'(wswapout),  32'(m_wso));
        check({tag, ".activeout"}, 32'(activeout), 32'(m_ao));
        check({tag, ".wvalid"},    32'(wvalid),    32'(m_valid));
`ifdef PE_SATURATE_EN
        check({tag, ".sat_flag"},  32'(sat_flag),  32'(m_sat));
`endif
    endtask

    task automatic drive(input logic rn, input logic a, input logic [7:0] d, input logic [15:0] s,
                         input logic [7:0] w, input logic ww, input logic ws);
        reset_n = rn; active = a; datain = d; sumin = s; win = w; wwrite = ww; wswap = ws;
    endtask

    initial begin
        m_shadow = 0; m_act = 0; m_valid = 0; m_mac = 0; m_dout = 0;
        m_wwo = 0; m_wso = 0; m_ao = 0; m_sat = 0;

        // Reset with random inputs for two cycles
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 8'($urandom), 16'($urandom), 8'($urandom), 1'b1, 1'b1);
            tick("reset");
        end
        check("reset.maccout_zero", 32'(maccout), 32'd0);
        check("reset.wvalid_zero",  32'(wvalid),  32'd0);
        check("reset.wout_zero",    32'(wout),    32'd0);

        drive(1'b1, 1'b0, 8'd0, 16'd0, 8'd0, 1'b0, 1'b0);
        tick("idle");

        // Load 5 then swap, then MAC 10 + 3*5
        drive(1'b1, 1'b0, 8'd0, 16'd0, 8'h05, 1'b1, 1'b0);
        tick("load5");
        drive(1'b1, 1'b0, 8'd0, 16'd0, 8'h00, 1'b0, 1'b1);
        tick("swap5");
        check("swap5.wout_lit",     32'(wout),     32'h05);
        check("swap5.wswapout_lit", 32'(wswapout), 32'd1);
        check("swap5.wvalid_lit",   32'(wvalid),   32'd1);
        drive(1'b1, 1'b1, 8'd3, 16'd10, 8'h00, 1'b0, 1'b0);
        tick("mac25");
        check("mac25.lit", 32'(maccout), 32'd25);

        // Shift in 7 while computing with 5; swap later
        drive(1'b1, 1'b1, 8'd2, 16'd0, 8'h07, 1'b1, 1'b0);
        tick("dbuf_write");
        check("dbuf_write.lit", 32'(maccout), 32'd10);
        drive(1'b1, 1'b1, 8'd2, 16'd0, 8'h00, 1'b0, 1'b0);
        tick("dbuf_hold");
        check("dbuf_hold.lit", 32'(maccout), 32'd10);
        drive(1'b1, 1'b1, 8'd2, 16'd0, 8'h00, 1'b0, 1'b1);
        tick("dbuf_swap");
        check("dbuf_swap.lit", 32'(maccout), 32'd10);
        drive(1'b1, 1'b1, 8'd2, 16'd0, 8'h00, 1'b0, 1'b0);
        tick("dbuf_new");
        check("dbuf_new.lit", 32'(maccout), 32'd14);

        // Same-edge swap and write: active takes old shadow 5, chain takes 9
        drive(1'b1, 1'b0, 8'd0, 16'd0, 8'h05, 1'b1, 1'b0);
        tick("same_load");
        drive(1'b1, 1'b0, 8'd0, 16'd0, 8'h09, 1'b1, 1'b1);
        tick("same_edge");
        check("same_edge.wout_lit", 32'(wout), 32'h09);
        drive(1'b1, 1'b1, 8'd1, 16'd0, 8'h00, 1'b0, 1'b0);
        tick("same_use");
        check("same_use.act_w_lit", 32'(maccout), 32'd5);

        // Overflow: 0x7FFF + 0x7F*0x7F
        drive(1'b1, 1'b0, 8'd0, 16'd0, 8'h7F, 1'b1, 1'b0);
        tick("ovf_load");
        drive(1'b1, 1'b0, 8'd0, 16'd0, 8'h00, 1'b0, 1'b1);
        tick("ovf_swap");
        drive(1'b1, 1'b1, 8'h7F, 16'h7FFF, 8'h00, 1'b0, 1'b0);
        tick("ovf");
`ifdef PE_SATURATE_EN
        check("ovf.sat_lit",  32'(maccout),  32'h7FFF);
        check("ovf.flag_lit", 32'(sat_flag), 32'd1);
`else
        check("ovf.wrap_lit", 32'(maccout), 32'hBF00);
`endif
        drive(1'b1, 1'b0, 8'($urandom), 16'($urandom), 8'h00, 1'b0, 1'b0);
        tick("hold");
`ifdef PE_SATURATE_EN
        check("hold.lit", 32'(maccout), 32'h7FFF);
`else
        check("hold.lit", 32'(maccout), 32'hBF00);
`endif
        check("hold.activeout_lit", 32'(activeout), 32'd0);

        // Reset in the middle of an active stream
        drive(1'b1, 1'b1, 8'd4, 16'd100, 8'h00, 1'b0, 1'b0);
        tick("pre_rst");
        drive(1'b0, 1'b1, 8'd4, 16'd100, 8'h00, 1'b0, 1'b0);
        tick("mid_rst");
        check("mid_rst.lit", 32'(maccout), 32'd0);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 31) != 0), 1'($urandom), 8'($urandom), 16'($urandom),
                  8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
